// File: rtl/shift_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : shift_ctrl_unit
// Description : Moore control FSM driving Load / Shift_En / Clr_Out strobes of
//               a serial register chain; N_SHIFTS shifts per Execute press.
//               Optional Shift_Cnt port enabled by SHIFT_CTRL_CNT_OUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_ctrl_unit #(
    parameter  int N_SHIFTS = 8,
    localparam int CW       = $clog2(N_SHIFTS + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Execute,
    input  logic          LoadReq,
    input  logic          ClrReq,
    output logic          Load,
    output logic          Shift_En,
    output logic          Clr_Out,
    output logic          Busy,
    output logic          Done
`ifdef SHIFT_CTRL_CNT_OUT_EN
    ,
    output logic [CW-1:0] Shift_Cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [CW-1:0] C_LAST_CNT = CW'(N_SHIFTS - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode from the registered state only, so the strobes are one-hot.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        Load     = 1'b0;
        Shift_En = 1'b0;
        Clr_Out  = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ClrReq) begin
                    state_d = S_CLR;
                end else if (LoadReq) begin
                    state_d = S_LOAD;
                end else if (Execute) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_CLR: begin
                Clr_Out = 1'b1;
                state_d = S_IDLE;
            end
            S_LOAD: begin
                Load    = 1'b1;
                state_d = S_IDLE;
            end
            S_SHIFT: begin
                Shift_En = 1'b1;
                Busy     = 1'b1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == C_LAST_CNT) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                Done = 1'b1;
                // Wait for release so one press gives exactly one run.
                if (!Execute) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef SHIFT_CTRL_CNT_OUT_EN
    assign Shift_Cnt = cnt_q;
`else
    // Counter remains internal; it only sequences the SHIFT state.
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_ctrl_unit
// Description : Directed self-checking bench for shift_ctrl_unit (N_SHIFTS=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_ctrl_unit;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          Clk = 1'b0;
    logic          Reset, Execute, LoadReq, ClrReq;
    logic          Load, Shift_En, Clr_Out, Busy, Done;
`ifdef SHIFT_CTRL_CNT_OUT_EN
    logic [CW-1:0] Shift_Cnt;
`endif

    int n_chk  = 0;
    int n_err  = 0;
    int n_shift = 0;
    int n_load  = 0;
    int n_clr   = 0;
    int n_excl  = 0;

    shift_ctrl_unit #(.N_SHIFTS(N)) u_dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Execute  (Execute),
        .LoadReq  (LoadReq),
        .ClrReq   (ClrReq),
        .Load     (Load),
        .Shift_En (Shift_En),
        .Clr_Out  (Clr_Out),
        .Busy     (Busy),
        .Done     (Done)
`ifdef SHIFT_CTRL_CNT_OUT_EN
        ,
        .Shift_Cnt(Shift_Cnt)
`endif
    );

    always #5 Clk = ~Clk;

    // Strobe tally and exclusivity monitor, sampled mid-cycle.
    always @(negedge Clk) begin
        if (Shift_En) n_shift++;
        if (Load)     n_load++;
        if (Clr_Out)  n_clr++;
        if ((32'(Load) + 32'(Shift_En) + 32'(Clr_Out)) > 1) n_excl++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // {Load, Shift_En, Clr_Out, Busy, Done}
    function automatic logic [31:0] outs();
        return {27'd0, Load, Shift_En, Clr_Out, Busy, Done};
    endfunction

    task automatic clear_tally();
        n_shift = 0;
        n_load  = 0;
        n_clr   = 0;
    endtask

    initial begin
        Reset = 1'b1; Execute = 1'b0; LoadReq = 1'b0; ClrReq = 1'b0;
        tick();
        tick();
        check("reset_outs", outs(), 32'b00000);
`ifdef SHIFT_CTRL_CNT_OUT_EN
        check("reset_cnt", 32'(Shift_Cnt), 0);
`endif
        Reset = 1'b0;
        tick();
        check("idle_outs", outs(), 32'b00000);

        // Basic run: Execute held 20 cycles.
        clear_tally();
        Execute = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            check($sformatf("run_shift%0d", i), outs(), 32'b01010);
`ifdef SHIFT_CTRL_CNT_OUT_EN
            check($sformatf("run_cnt%0d", i), 32'(Shift_Cnt), 32'(i));
`endif
            tick();
        end
        check("run_done", outs(), 32'b00001);
`ifdef SHIFT_CTRL_CNT_OUT_EN
        check("hold_cnt", 32'(Shift_Cnt), 32'(N));
`endif
        for (int i = 0; i < 11; i++) tick();
        check("hold_stays", outs(), 32'b00001);
        Execute = 1'b0;
        tick();
        check("release_idle", outs(), 32'b00000);
        check("run_strobes", 32'(n_shift), 32'(N));

        // Priority: Clr > Load > Execute.
        clear_tally();
        ClrReq = 1'b1; LoadReq = 1'b1; Execute = 1'b1;
        tick();
        check("prio_clr", outs(), 32'b00100);
        tick();
        check("prio_back_idle", outs(), 32'b00000);
        ClrReq = 1'b0;
        tick();
        check("prio_load", outs(), 32'b10000);
        LoadReq = 1'b0; Execute = 1'b0;
        tick();
        check("prio_end_idle", outs(), 32'b00000);
        check("prio_no_shift", 32'(n_shift), 0);
        check("prio_clr_cnt", 32'(n_clr), 1);
        check("prio_load_cnt", 32'(n_load), 1);

        // Requests ignored in SHIFT and HOLD.
        clear_tally();
        Execute = 1'b1;
        tick();
`ifdef SHIFT_CTRL_CNT_OUT_EN
        check("rerun_cnt0", 32'(Shift_Cnt), 0);
`endif
        tick(); tick(); tick();
        LoadReq = 1'b1; ClrReq = 1'b1;
        tick();
        LoadReq = 1'b0; ClrReq = 1'b0;
        for (int i = 0; i < 20 && !Done; i++) tick();
        check("ign_done", outs(), 32'b00001);
        LoadReq = 1'b1; ClrReq = 1'b1;
        tick(); tick(); tick();
        check("ign_hold", outs(), 32'b00001);
        Execute = 1'b0; LoadReq = 1'b0; ClrReq = 1'b0;
        tick();
        check("ign_idle", outs(), 32'b00000);
        check("ign_strobes", 32'(n_shift), 32'(N));
        check("ign_no_load", 32'(n_load + n_clr), 0);

        // Reset during the fifth shift cycle.
        clear_tally();
        Execute = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("abort_pre", outs(), 32'b01010);
        Reset = 1'b1;
        tick();
        check("abort_outs", outs(), 32'b00000);
        check("abort_strobes", 32'(n_shift), 5);
`ifdef SHIFT_CTRL_CNT_OUT_EN
        check("abort_cnt", 32'(Shift_Cnt), 0);
`endif
        Reset = 1'b0; Execute = 1'b0;
        tick();
        check("abort_idle", outs(), 32'b00000);

        clear_tally();
        Execute = 1'b1;
        tick();
        for (int i = 0; i < 20 && !Done; i++) tick();
        check("after_done", outs(), 32'b00001);
        Execute = 1'b0;
        tick();
        check("after_strobes", 32'(n_shift), 32'(N));
        check("exclusive", 32'(n_excl), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
